// File: rtl/frame_strobe_sequencer.sv
// -----------------------------------------------------------------------------
// frame_strobe_sequencer
//
// Column-level configuration sequencer placed directly above the north terminal
// tile of one fabric column. It parses a 32-bit configuration word stream,
// loads one frame of row data into FrameData, and then fires a single-cycle
// one-hot FrameStrobe. The terminal tile buffers that pulse and forwards it
// down the column. Each column has its own instance, selected by ColumnIndex.
//
// Ports
//   CLK          configuration clock, rising edge
//   Reset        asynchronous, active-high reset
//   WriteData    configuration word
//   WriteStrobe  WriteData valid; a word is taken when WriteStrobe && Ready
//   Ready        a word can be accepted this cycle (low only while strobing)
//   FrameData    row frame data, row k at [k*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  one-hot, single-cycle frame write strobe to the column
//   ConfigActive high while synchronised (any state other than IDLE)
//   Error        sticky frame-index error, cleared by the next sync word
//
// Word stream
//   0xFAB0_FAB1                 sync word, accepted only in IDLE
//   0xFFFF_FFFF                 desync word, recognised only in HEADER
//   header [31:24]=column, [20:16]=frame index
//   NumberOfRows data words, row 0 first
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | not synchronised; every word except the sync word is dropped
// HEADER | synchronised; the next word is a header or a desync
// DATA   | collecting row words for the latched frame
// STROBE | one cycle: FrameStrobe pulses, no word is accepted
// -----------------------------------------------------------------------------
module frame_strobe_sequencer #(
  parameter int         MaxFramesPerCol = 20,
  parameter int         FrameBitsPerRow = 32,
  parameter int         NumberOfRows    = 4,
  parameter logic [7:0] ColumnIndex     = 8'd0
) (
  input  logic                                    CLK,
  input  logic                                    Reset,
  input  logic [31:0]                             WriteData,
  input  logic                                    WriteStrobe,
  output logic                                    Ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    ConfigActive,
  output logic                                    Error
);

  localparam int RowCntW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [RowCntW-1:0] LastRow = RowCntW'(NumberOfRows - 1);
  localparam logic [31:0] SyncWord   = 32'hFAB0_FAB1;
  localparam logic [31:0] DesyncWord = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [RowCntW-1:0]                      row_cnt, row_cnt_next;
  logic [7:0]                              col_q, col_next;
  logic [4:0]                              frame_q, frame_next;
  logic [NumberOfRows*FrameBitsPerRow-1:0] frame_data_next;
  logic [MaxFramesPerCol-1:0]              frame_strobe_next;
  logic                                    ready_next;
  logic                                    config_active_next;
  logic                                    error_next;
  logic                                    accept;

  // Ready is a registered copy of "not in STROBE", so this is the true
  // handshake; words offered while Ready is low simply fall on the floor.
  assign accept = WriteStrobe && Ready;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      row_cnt      <= '0;
      col_q        <= '0;
      frame_q      <= '0;
      FrameData    <= '0;
      FrameStrobe  <= '0;
      Ready        <= 1'b1;
      ConfigActive <= 1'b0;
      Error        <= 1'b0;
    end else begin
      state        <= state_next;
      row_cnt      <= row_cnt_next;
      col_q        <= col_next;
      frame_q      <= frame_next;
      FrameData    <= frame_data_next;
      FrameStrobe  <= frame_strobe_next;
      Ready        <= ready_next;
      ConfigActive <= config_active_next;
      Error        <= error_next;
    end
  end

  always_comb begin
    state_next        = state;
    row_cnt_next      = row_cnt;
    col_next          = col_q;
    frame_next        = frame_q;
    frame_data_next   = FrameData;
    frame_strobe_next = '0;
    error_next        = Error;

    case (state)
      IDLE: begin
        if (accept && (WriteData == SyncWord)) begin
          state_next = HEADER;
          error_next = 1'b0;
        end
      end

      HEADER: begin
        if (accept) begin
          if (WriteData == DesyncWord) begin
            state_next = IDLE;
          end else begin
            // Fields are latched even for a bad index so the last header
            // seen stays observable; the bad index itself never strobes.
            col_next     = WriteData[31:24];
            frame_next   = WriteData[20:16];
            row_cnt_next = '0;
            if (int'(WriteData[20:16]) >= MaxFramesPerCol) begin
              error_next = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = DATA;
            end
          end
        end
      end

      DATA: begin
        // Sync and desync patterns are ordinary payload here.
        if (accept) begin
          for (int r = 0; r < NumberOfRows; r++) begin
            if (row_cnt == RowCntW'(r)) begin
              frame_data_next[r*FrameBitsPerRow +: FrameBitsPerRow] =
                WriteData[FrameBitsPerRow-1:0];
            end
          end
          if (row_cnt == LastRow) begin
            // Counter returns to zero through the state change only.
            row_cnt_next = '0;
            state_next   = STROBE;
            if (col_q == ColumnIndex) begin
              frame_strobe_next = MaxFramesPerCol'(1) << frame_q;
            end
          end else begin
            row_cnt_next = row_cnt + 1'b1;
          end
        end
      end

      STROBE: begin
        state_next = HEADER;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    ready_next         = (state_next != STROBE);
    config_active_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_strobe_sequencer
//
// Self-checking bench for frame_strobe_sequencer (default parameters,
// ColumnIndex = 0). Directed scenarios check against hand-derived constants;
// a randomized word stream is checked every cycle against a word-level
// reference model kept in this file.
// -----------------------------------------------------------------------------
module tb_frame_strobe_sequencer;

  localparam int NF = 20;
  localparam int NR = 4;

  logic          CLK;
  logic          Reset;
  logic [31:0]   WriteData;
  logic          WriteStrobe;
  logic          Ready;
  logic [127:0]  FrameData;
  logic [NF-1:0] FrameStrobe;
  logic          ConfigActive;
  logic          Error;

  int checks = 0;
  int errors = 0;

  frame_strobe_sequencer #(
    .MaxFramesPerCol(NF),
    .FrameBitsPerRow(32),
    .NumberOfRows(NR),
    .ColumnIndex(8'd0)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .WriteData(WriteData),
    .WriteStrobe(WriteStrobe),
    .Ready(Ready),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .ConfigActive(ConfigActive),
    .Error(Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model (word-stream level) ----------------
  bit          m_synced;      // sync seen and not yet desynced / errored
  bit          m_in_frame;    // header taken, rows still to come
  bit          m_strobing;    // the cycle right after the last row
  int          m_rows_got;
  logic [31:0] m_rows [NR];
  logic [7:0]  m_col;
  int          m_frame;
  bit          m_err;

  function automatic void model_reset();
    m_synced = 0; m_in_frame = 0; m_strobing = 0; m_rows_got = 0;
    m_col = 0; m_frame = 0; m_err = 0;
    for (int k = 0; k < NR; k++) m_rows[k] = 32'h0;
  endfunction

  function automatic void model_step(input bit ws, input logic [31:0] wd);
    if (m_strobing) begin
      m_strobing = 0;               // word offered now is lost
    end else if (ws) begin
      if (!m_synced) begin
        if (wd == 32'hFAB0_FAB1) begin m_synced = 1; m_err = 0; end
      end else if (!m_in_frame) begin
        if (wd == 32'hFFFF_FFFF) m_synced = 0;
        else begin
          m_col = wd[31:24];
          m_frame = int'(wd[20:16]);
          if (m_frame >= NF) begin m_err = 1; m_synced = 0; end
          else begin m_in_frame = 1; m_rows_got = 0; end
        end
      end else begin
        m_rows[m_rows_got] = wd;
        m_rows_got++;
        if (m_rows_got == NR) begin m_in_frame = 0; m_strobing = 1; end
      end
    end
  endfunction

  function automatic logic [NF-1:0] model_strobe();
    logic [NF-1:0] s;
    s = '0;
    if (m_strobing && m_col == 8'd0) s[m_frame] = 1'b1;
    return s;
  endfunction

  function automatic logic [127:0] model_data();
    logic [127:0] d;
    for (int k = 0; k < NR; k++) d[k*32 +: 32] = m_rows[k];
    return d;
  endfunction

  // Drive one cycle: inputs change 1 time unit after an edge, outputs are
  // sampled 1 time unit after the next edge.
  task automatic cycle(input bit ws, input logic [31:0] wd);
    WriteStrobe = ws;
    WriteData   = wd;
    @(posedge CLK);
    model_step(ws, wd);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b1; WriteStrobe = 1'b0; WriteData = 32'h0;
    model_reset();
    #12;
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", Ready); end
    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL reset_strobe got %h exp 0", FrameStrobe); end
    checks++; if (FrameData !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", FrameData); end
    checks++; if (ConfigActive !== 1'b0 || Error !== 1'b0) begin errors++; $display("FAIL reset_flags got act=%b err=%b exp 0 0", ConfigActive, Error); end
    Reset = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic_frame();
    cycle(1, 32'hFAB0_FAB1);
    checks++; if (ConfigActive !== 1'b1) begin errors++; $display("FAIL basic_sync_active got %b exp 1", ConfigActive); end
    cycle(1, 32'h0003_0000);
    cycle(1, 32'h1111_1111);
    cycle(1, 32'h2222_2222);
    cycle(1, 32'h3333_3333);
    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL basic_early_strobe got %h exp 0", FrameStrobe); end
    cycle(1, 32'h4444_4444);
    checks++; if (FrameStrobe !== 20'h00008) begin errors++; $display("FAIL basic_strobe got %h exp 00008", FrameStrobe); end
    checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low got %b exp 0", Ready); end
    checks++; if (FrameData !== 128'h44444444_33333333_22222222_11111111) begin errors++; $display("FAIL basic_data got %h", FrameData); end
    cycle(1, 32'hDEAD_BEEF);        // offered during STROBE, must be dropped
    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL basic_strobe_len got %h exp 0", FrameStrobe); end
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got %b exp 1", Ready); end
    checks++; if (FrameData !== 128'h44444444_33333333_22222222_11111111) begin errors++; $display("FAIL basic_data_hold got %h", FrameData); end
  endtask

  task automatic test_column_mismatch();
    logic [NF-1:0] seen;
    seen = '0;
    cycle(1, 32'h0505_0000);
    for (int k = 0; k < NR; k++) begin
      cycle(1, 32'hA000_0000 + k);
      seen |= FrameStrobe;
    end
    cycle(0, 32'h0);
    seen |= FrameStrobe;
    checks++; if (seen !== '0) begin errors++; $display("FAIL colmis_strobe got %h exp 0", seen); end
    checks++; if (FrameData !== 128'hA0000003_A0000002_A0000001_A0000000) begin errors++; $display("FAIL colmis_data got %h", FrameData); end
    cycle(1, 32'h0002_0000);
    for (int k = 0; k < NR; k++) cycle(1, 32'h0);
    checks++; if (FrameStrobe !== 20'h00004) begin errors++; $display("FAIL colmis_next_hdr got %h exp 00004", FrameStrobe); end
    cycle(0, 32'h0);
  endtask

  task automatic test_bad_frame();
    logic [NF-1:0] seen;
    seen = '0;
    cycle(1, 32'h0014_0000);
    checks++; if (Error !== 1'b1) begin errors++; $display("FAIL bad_error got %b exp 1", Error); end
    checks++; if (ConfigActive !== 1'b0) begin errors++; $display("FAIL bad_active got %b exp 0", ConfigActive); end
    for (int k = 0; k < NR + 1; k++) begin
      cycle(1, 32'h5555_0000 + k);
      seen |= FrameStrobe;
    end
    checks++; if (seen !== '0) begin errors++; $display("FAIL bad_strobe got %h exp 0", seen); end
    checks++; if (Error !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b exp 1", Error); end
    cycle(1, 32'hFAB0_FAB1);
    checks++; if (Error !== 1'b0 || ConfigActive !== 1'b1) begin errors++; $display("FAIL bad_clear got err=%b act=%b exp 0 1", Error, ConfigActive); end
  endtask

  task automatic test_gap_back_to_back();
    // In HEADER after the sync of the previous scenario.
    cycle(1, 32'h0000_0000);
    for (int k = 0; k < NR; k++) begin
      idle(3);
      checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL gap_strobe_early row=%0d got %h exp 0", k, FrameStrobe); end
      cycle(1, 32'hC000_0000 + k);
    end
    checks++; if (FrameStrobe !== 20'h00001) begin errors++; $display("FAIL gap_strobe0 got %h exp 00001", FrameStrobe); end
    cycle(1, 32'h0013_0000);        // offered during STROBE, dropped
    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL gap_strobe0_len got %h exp 0", FrameStrobe); end
    cycle(1, 32'h0013_0000);
    for (int k = 0; k < NR; k++) cycle(1, 32'hD000_0000 + k);
    checks++; if (FrameStrobe !== 20'h80000) begin errors++; $display("FAIL gap_strobe19 got %h exp 80000", FrameStrobe); end
    checks++; if (FrameData !== 128'hD0000003_D0000002_D0000001_D0000000) begin errors++; $display("FAIL gap_data got %h", FrameData); end
    cycle(0, 32'h0);
    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL gap_strobe19_len got %h exp 0", FrameStrobe); end
  endtask

  task automatic test_desync_junk();
    logic [NF-1:0] seen;
    seen = '0;
    cycle(1, 32'hFFFF_FFFF);
    checks++; if (ConfigActive !== 1'b0) begin errors++; $display("FAIL desync_active got %b exp 0", ConfigActive); end
    cycle(1, 32'h0001_0000);
    for (int k = 0; k < NR + 1; k++) begin
      cycle(1, 32'h7777_0000 + k);
      seen |= FrameStrobe;
    end
    checks++; if (seen !== '0 || ConfigActive !== 1'b0) begin errors++; $display("FAIL desync_nostrobe got strobe=%h act=%b exp 0 0", seen, ConfigActive); end
    cycle(1, 32'hFAB0_FAB1);
    cycle(1, 32'h0006_0000);
    cycle(1, 32'hFFFF_FFFF);        // desync pattern is payload inside DATA
    for (int k = 1; k < NR; k++) cycle(1, 32'hFAB0_FAB1);
    checks++; if (FrameStrobe !== 20'h00040) begin errors++; $display("FAIL desync_in_data got %h exp 00040", FrameStrobe); end
    cycle(0, 32'h0);
  endtask

  task automatic test_async_reset();
    logic [NF-1:0] seen;
    seen = '0;
    cycle(1, 32'h0007_0000);
    cycle(1, 32'hE000_0000);
    cycle(1, 32'hE000_0001);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    checks++; if (FrameData !== '0 || ConfigActive !== 1'b0 || Ready !== 1'b1 || FrameStrobe !== '0) begin errors++; $display("FAIL rst_mid_data got data=%h act=%b rdy=%b exp 0 0 1", FrameData, ConfigActive, Ready); end
    @(posedge CLK); #1;
    Reset = 1'b0;
    for (int k = 0; k < NR; k++) begin
      cycle(1, 32'hE000_0002 + k);
      seen |= FrameStrobe;
    end
    checks++; if (seen !== '0 || ConfigActive !== 1'b0) begin errors++; $display("FAIL rst_mid_data_after got strobe=%h act=%b exp 0 0", seen, ConfigActive); end
    cycle(1, 32'hFAB0_FAB1);
    cycle(1, 32'h0002_0000);
    for (int k = 0; k < NR; k++) cycle(1, 32'hB000_0000 + k);
    checks++; if (FrameStrobe !== 20'h00004) begin errors++; $display("FAIL rst_pre_strobe got %h exp 00004", FrameStrobe); end
    #2 Reset = 1'b1;
    #1;
    model_reset();
    checks++; if (FrameStrobe !== '0 || Ready !== 1'b1 || FrameData !== '0) begin errors++; $display("FAIL rst_in_strobe got strobe=%h rdy=%b data=%h", FrameStrobe, Ready, FrameData); end
    @(posedge CLK); #1;
    Reset = 1'b0;
    seen = '0;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 32'h0);
      seen |= FrameStrobe;
    end
    checks++; if (seen !== '0 || ConfigActive !== 1'b0) begin errors++; $display("FAIL rst_in_strobe_after got strobe=%h act=%b exp 0 0", seen, ConfigActive); end
  endtask

  task automatic test_random();
    logic [31:0] wd;
    bit          ws;
    int          strobes;
    strobes = 0;
    for (int n = 0; n < 3000; n++) begin
      ws = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0, 1: wd = 32'hFAB0_FAB1;
        2:    wd = 32'hFFFF_FFFF;
        3, 4, 5: begin
          wd = $urandom;
          wd[31:24] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
          wd[20:16] = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, NF - 1));
        end
        default: wd = $urandom;
      endcase
      cycle(ws, wd);
      if (FrameStrobe != '0) strobes++;
      checks++; if (FrameStrobe !== model_strobe()) begin errors++; $display("FAIL rnd_strobe n=%0d got %h exp %h", n, FrameStrobe, model_strobe()); end
      checks++; if (FrameData !== model_data()) begin errors++; $display("FAIL rnd_data n=%0d got %h exp %h", n, FrameData, model_data()); end
      checks++; if (Ready !== !m_strobing) begin errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, Ready, !m_strobing); end
      checks++; if (ConfigActive !== m_synced) begin errors++; $display("FAIL rnd_active n=%0d got %b exp %b", n, ConfigActive, m_synced); end
      checks++; if (Error !== m_err) begin errors++; $display("FAIL rnd_error n=%0d got %b exp %b", n, Error, m_err); end
    end
    checks++; if (strobes == 0) begin errors++; $display("FAIL rnd_coverage got %0d strobes exp >0", strobes); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_column_mismatch();
    test_bad_frame();
    test_gap_back_to_back();
    test_desync_junk();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_strobe_sequencer.md
Name: frame_strobe_sequencer

Overview:
- Column-level configuration sequencer that sits directly upstream of the north terminal tile of one fabric column.
- It parses a 32-bit configuration word stream and loads row frame data into registers.
- It then issues a single-cycle, one-hot FrameStrobe pulse on the column's FrameStrobe input bus; the terminal tile buffers and forwards that pulse down the column.
- One instance is used per fabric column, selected by a compile-time column index.

Parameters:
- MaxFramesPerCol, 20, width of FrameStrobe; number of frames per column.
- FrameBitsPerRow, 32, bits of frame data per row; equals the word width.
- NumberOfRows, 4, number of data words per frame (one word per row).
- ColumnIndex, 0, 8-bit column address this instance responds to.

Ports:
- CLK  input  1  configuration clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- WriteData  input  32  configuration word.
- WriteStrobe  input  1  WriteData valid; a word is accepted when WriteStrobe && Ready.
- Ready  output  1  block can accept a word this cycle.
- FrameData  output  NumberOfRows*FrameBitsPerRow  row frame data; row k occupies bits [k*32 +: 32].
- FrameStrobe  output  MaxFramesPerCol  one-hot, single-cycle frame write strobe to the column.
- ConfigActive  output  1  high while synchronised (any state except IDLE).
- Error  output  1  sticky frame-index error flag.

Behaviour:
- Interface: one clock CLK; Reset is asynchronous and active-high.
- Reset values: state=IDLE, FrameData=0, FrameStrobe=0, Ready=1, ConfigActive=0, Error=0, row counter=0, latched header=0.
- All outputs are registered.
- Ready is low only in STROBE; words presented while Ready=0 are ignored, not queued.
- IDLE:
  - Accepted word 0xFAB0_FAB1 -> HEADER.
  - Any other accepted word is discarded and the state stays IDLE.
  - Error clears on sync word acceptance.
- HEADER:
  - Accepted 0xFFFF_FFFF (desync) -> IDLE.
  - Otherwise latch column = WriteData[31:24] and frame = WriteData[20:16], then -> DATA with row counter=0.
  - If frame >= MaxFramesPerCol: set Error and -> IDLE; no data phase and no strobe.
- DATA:
  - Each accepted word is written to FrameData row[counter], and counter increments.
  - The word accepted at counter == NumberOfRows-1 moves the state to STROBE.
  - Rows are updated only by accepted words; untouched rows hold their value.
  - A desync pattern inside DATA is treated as ordinary data.
- STROBE (exactly one cycle):
  - FrameStrobe[frame]=1 if latched column == ColumnIndex; otherwise FrameStrobe stays 0.
  - Next state is HEADER.
- Latency: last data word accepted at edge t -> FrameStrobe high during cycle t+1 only. It is low again after edge t+2, which is the first edge at which Ready=1 again.
- FrameData is stable from the last data word through the whole strobe cycle and is held until the next frame's first word. FrameStrobe is never asserted while FrameData is changing.
- FrameStrobe is never multi-hot. It is never high in IDLE, HEADER or DATA.
- Gaps: WriteStrobe gaps of any length in HEADER or DATA are legal; state and counter hold.
- Back-to-back frames: HEADER is entered directly after STROBE, with no re-sync needed.
- Reset mid-operation (any state, including during STROBE): everything returns to reset values immediately. FrameStrobe drops asynchronously and no partial frame strobes afterwards.
- Counter width: clog2(NumberOfRows), minimum 1 bit. It wraps only via the state transition, never arithmetically past NumberOfRows-1.

Test Plan:
- Basic frame (ColumnIndex=0):
  - Stimulus: sync, header 0x0003_0000, data 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Required: FrameData=0x44444444_33333333_22222222_11111111; FrameStrobe=0x00008 for exactly one cycle, one cycle after the last word; Ready=0 in that cycle.
- Column mismatch:
  - Stimulus: header 0x0505_0000 plus 4 data words.
  - Required: FrameData updates, FrameStrobe stays 0, state returns to HEADER (next header is accepted).
- Bad frame index:
  - Stimulus: header 0x0014_0000 (frame 20).
  - Required: Error=1, ConfigActive=0, no strobe. A subsequent sync clears Error.
- Gapped and back-to-back frames:
  - Stimulus: frame 0 data with WriteStrobe gaps of 3 cycles, followed immediately by a frame 19 header and data.
  - Required: strobes 0x00001 then 0x80000, one cycle each; the word presented during STROBE is not accepted.
- Desync and junk:
  - Stimulus: words before sync are ignored; 0xFFFF_FFFF in HEADER returns to IDLE (ConfigActive=0).
  - Required: a following header without re-sync produces no strobe.
- Async reset:
  - Stimulus: assert Reset mid-DATA (2 rows written) and again during the STROBE cycle.
  - Required: outputs go to reset values immediately, FrameStrobe=0, no strobe after Reset is released.
